// File: rtl/round_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 single-precision round-to-nearest-even
// stage among NREQ requesters, with a single registered output slot.
module round_arbiter #(
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_sign,
  input  logic [NREQ*8-1:0]  req_exp,
  input  logic [NREQ*23-1:0] req_mant,
  input  logic [NREQ*3-1:0]  req_grs,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_result,
  output logic [IDW-1:0]     out_id
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] ptr, win, ptr_next;
  logic           any_valid, can_accept, accept;

  logic [7:0]     exp_a  [NREQ];
  logic [22:0]    mant_a [NREQ];
  logic [2:0]     grs_a  [NREQ];

  logic [7:0]     sel_exp;
  logic [22:0]    sel_mant;
  logic [2:0]     sel_grs;
  logic           sel_sign, round_up;
  logic [30:0]    base_mag, rounded_mag;
  logic [31:0]    rounded;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      exp_a[i]  = req_exp[8*i +: 8];
      mant_a[i] = req_mant[23*i +: 23];
      grs_a[i]  = req_grs[3*i +: 3];
    end
  end

  // Grant search starts at ptr and wraps; the first pending requester wins.
  always_comb begin
    logic [IDW-1:0] idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win       = ptr;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win       = idx;
      end
    end
  end

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  assign accept     = any_valid && can_accept && !rst;
  assign ptr_next   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  // Round to nearest even on the 31-bit magnitude; the all-ones magnitude saturates.
  always_comb begin
    sel_sign    = req_sign[win];
    sel_exp     = exp_a[win];
    sel_mant    = mant_a[win];
    sel_grs     = grs_a[win];
    base_mag    = {sel_exp, sel_mant};
    round_up    = sel_grs[2] && (sel_grs[1] || sel_grs[0] || sel_mant[0]);
    rounded_mag = (round_up && (base_mag != '1)) ? base_mag + 31'd1 : base_mag;
    rounded     = {sel_sign, rounded_mag};
  end

  always_comb begin
    state_next = state;
    if (accept)                        state_next = FULL;
    else if (state == FULL && out_ready) state_next = EMPTY;
  end

  always_ff @(posedge clk) begin
    // NOTE: the output word and id are reset too, because consumers observe them as zero after reset.
    if (rst) begin
      state      <= EMPTY;
      ptr        <= '0;
      out_result <= '0;
      out_id     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (accept) begin
        out_result <= rounded;
        out_id     <= win;
        ptr        <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_round_arbiter.sv
// Self-checking bench for round_arbiter: directed cases plus randomized traffic
// checked against a behavioural model of grant order and rounding.
module tb_round_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, req_sign;
  logic [N*8-1:0]  req_exp;
  logic [N*23-1:0] req_mant;
  logic [N*3-1:0]  req_grs;
  logic          out_valid, out_ready;
  logic [31:0]   out_result;
  logic [1:0]    out_id;

  int checks = 0;
  int errors = 0;

  bit          m_valid;
  logic [31:0] m_result;
  int          m_id, m_ptr;

  round_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
    .req_exp(req_exp), .req_mant(req_mant), .req_grs(req_grs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_id(out_id)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int i, bit v, bit s, logic [7:0] e, logic [22:0] m, logic [2:0] g);
    req_valid[i]        = v;
    req_sign[i]         = s;
    req_exp[8*i +: 8]   = e;
    req_mant[23*i +: 23] = m;
    req_grs[3*i +: 3]   = g;
  endtask

  // Rounding by ulp fraction: tail in eighths of an ulp, above half rounds up, exactly half goes to even.
  function automatic logic [31:0] model_round(int i);
    longint mag;
    int     tail;
    mag  = longint'({req_exp[8*i +: 8], req_mant[23*i +: 23]});
    tail = int'(req_grs[3*i +: 3]);
    if (tail > 4 || (tail == 4 && (mag % 2) == 1))
      if (mag != 64'h7FFF_FFFF) mag = mag + 1;
    return {req_sign[i], mag[30:0]};
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // One clock: check combinational grant, advance model at the edge, check registered outputs.
  task automatic cycle(string tag);
    int         w;
    bit         was_rst;
    logic [N-1:0] er;
    #1;
    w  = model_winner();
    er = '0;
    if (!rst && w >= 0 && (!m_valid || out_ready)) er[w] = 1'b1;
    check({tag, ":ready"}, 32'(req_ready), 32'(er));
    @(posedge clk);
    was_rst = rst;
    if (was_rst) begin
      m_valid = 0; m_result = '0; m_id = 0; m_ptr = 0;
    end else if (er != '0) begin
      m_valid = 1; m_result = model_round(w); m_id = w; m_ptr = (w + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
    check({tag, ":valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid || was_rst) begin
      check({tag, ":result"}, out_result, m_result);
      check({tag, ":id"}, 32'(out_id), 32'(m_id));
    end
  endtask

  task automatic all_valid_random();
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'($urandom), 8'($urandom), 23'($urandom), 3'($urandom));
  endtask

  int seq_a [5] = '{0, 1, 2, 3, 0};
  int seq_b [4] = '{0, 2, 3, 0};

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    req_valid = '0; req_sign = '0; req_exp = '0; req_mant = '0; req_grs = '0;
    m_valid = 0; m_result = '0; m_id = 0; m_ptr = 0;
    cycle("reset0");
    cycle("reset1");
    check("reset_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // T1: tie rounding with odd and even lsb
    set_req(0, 1, 0, 8'h7F, 23'h000001, 3'b100); cycle("t1a");
    check("t1a_const", out_result, 32'h3F80_0002);
    check("t1a_id", 32'(out_id), 32'd0);
    set_req(0, 1, 0, 8'h7F, 23'h000000, 3'b100); cycle("t1b");
    check("t1b_const", out_result, 32'h3F80_0000);

    // T2: mantissa carry into exponent, truncation, negative round-up
    set_req(0, 1, 0, 8'h7F, 23'h7FFFFF, 3'b110); cycle("t2a");
    check("t2a_const", out_result, 32'h4000_0000);
    set_req(0, 1, 0, 8'h7F, 23'h7FFFFF, 3'b011); cycle("t2b");
    check("t2b_const", out_result, 32'h3FFF_FFFF);
    set_req(0, 1, 1, 8'h7F, 23'h000000, 3'b101); cycle("t2c");
    check("t2c_const", out_result, 32'hBF80_0001);

    // T3: saturation keeps sign
    set_req(0, 1, 0, 8'hFF, 23'h7FFFFF, 3'b111); cycle("t3a");
    check("t3a_const", out_result, 32'h7FFF_FFFF);
    set_req(0, 1, 1, 8'hFF, 23'h7FFFFF, 3'b111); cycle("t3b");
    check("t3b_const", out_result, 32'hFFFF_FFFF);
    req_valid = '0;
    cycle("t3_drain");

    // T4: round-robin order, then with req1 dropped
    rst = 1'b1; cycle("t4_rst"); rst = 1'b0;
    out_ready = 1'b1;
    all_valid_random();
    for (int k = 0; k < 5; k++) begin
      cycle("t4a");
      check("t4a_order", 32'(out_id), 32'(seq_a[k]));
      check("t4a_onehot", 32'($onehot(req_ready)), 32'd1);
    end
    rst = 1'b1; cycle("t4_rst2"); rst = 1'b0;
    all_valid_random();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle("t4b");
      check("t4b_order", 32'(out_id), 32'(seq_b[k]));
    end

    // T5: backpressure holds the slot, then drain and refill in one cycle
    rst = 1'b1; cycle("t5_rst"); rst = 1'b0;
    all_valid_random();
    out_ready = 1'b0;
    cycle("t5_fill");
    for (int k = 0; k < 3; k++) begin
      cycle("t5_hold");
      check("t5_hold_id", 32'(out_id), 32'd0);
      check("t5_hold_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle("t5_refill");
    check("t5_refill_id", 32'(out_id), 32'd1);
    check("t5_refill_valid", 32'(out_valid), 32'd1);

    // T6: reset while full discards the held word
    out_ready = 1'b0;
    req_valid = '1;
    rst = 1'b1;
    cycle("t6_rst");
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_id", 32'(out_id), 32'd0);
    rst = 1'b0;
    #1;
    check("t6_first_grant", 32'(req_ready), 32'b0001);
    cycle("t6_after");
    check("t6_after_id", 32'(out_id), 32'd0);

    // Randomized traffic with occasional saturation operands and resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0)
          set_req(i, 1'($urandom), 1'($urandom), 8'hFF, 23'h7FFFFF, 3'($urandom));
        else
          set_req(i, 1'($urandom), 1'($urandom), 8'($urandom), 23'($urandom), 3'($urandom));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
